id_exe_reg: RTL and testbench

Pipeline register between Instruction Decode and Execute. It captures every decoded field of the current instruction on each rising clock edge and presents it to the Execute stage one cycle later. The Execute stage's second-operand generator consumes `shifter_operand_out`, `imm_out`, `is_for_memory_out` and `val_Rm_out` directly. The block implements pipeline hold, branch flush and hazard bubble insertion, and can optionally count those events.

---
 rtl/id_exe_reg.sv | 173 +++++++++++++++++
 tb/tb_id_exe_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with hold, flush and hazard-bubble handling.
// Optional event counters are built when ID_EXE_PERF_CNT_EN is defined.
module id_exe_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic        hazard,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_Rn_in,
  input  logic [31:0] val_Rm_in,
  input  logic [11:0] shifter_operand_in,
  input  logic        imm_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        wb_en_in,
  input  logic        b_in,
  input  logic        s_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  src1_in,
  input  logic [3:0]  src2_in,
  input  logic        sr_c_in,
  output logic [31:0] pc_out,
  output logic [31:0] val_Rn_out,
  output logic [31:0] val_Rm_out,
  output logic [11:0] shifter_operand_out,
  output logic        imm_out,
  output logic [23:0] signed_imm_24_out,
  output logic [3:0]  exe_cmd_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        wb_en_out,
  output logic        b_out,
  output logic        s_out,
  output logic        is_for_memory_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  src1_out,
  output logic [3:0]  src2_out,
  output logic        sr_c_out,
  output logic        valid_out,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] hold_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] sh;
    logic        imm;
    logic [23:0] si24;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        b;
    logic        s;
    logic        mem;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        c;
    logic        v;
  } id_ex_t;

  id_ex_t st_q, st_d, ld;

  always_comb begin
    ld      = '0;
    ld.pc   = pc_in;
    ld.rn   = val_Rn_in;
    ld.rm   = val_Rm_in;
    ld.sh   = shifter_operand_in;
    ld.imm  = imm_in;
    ld.si24 = signed_imm_24_in;
    ld.cmd  = exe_cmd_in;
    ld.mr   = mem_r_en_in;
    ld.mw   = mem_w_en_in;
    ld.wb   = wb_en_in;
    ld.b    = b_in;
    ld.s    = s_in;
    ld.mem  = mem_r_en_in | mem_w_en_in;
    ld.dest = dest_in;
    ld.src1 = src1_in;
    ld.src2 = src2_in;
    ld.c    = sr_c_in;
    ld.v    = 1'b1;
  end

  // A killed slot is all-zero: the NOP encoding, no side effects.
  always_comb begin
    st_d = st_q;
    if (hold)
      st_d = st_q;
    else if (flush || hazard)
      st_d = '0;
    else
      st_d = ld;
  end

  always_ff @(posedge clk) begin
    if (rst)
      st_q <= '0;
    else
      st_q <= st_d;
  end

  assign pc_out              = st_q.pc;
  assign val_Rn_out          = st_q.rn;
  assign val_Rm_out          = st_q.rm;
  assign shifter_operand_out = st_q.sh;
  assign imm_out             = st_q.imm;
  assign signed_imm_24_out   = st_q.si24;
  assign exe_cmd_out         = st_q.cmd;
  assign mem_r_en_out        = st_q.mr;
  assign mem_w_en_out        = st_q.mw;
  assign wb_en_out           = st_q.wb;
  assign b_out               = st_q.b;
  assign s_out               = st_q.s;
  assign is_for_memory_out   = st_q.mem;
  assign dest_out            = st_q.dest;
  assign src1_out            = st_q.src1;
  assign src2_out            = st_q.src2;
  assign sr_c_out            = st_q.c;
  assign valid_out           = st_q.v;

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] hold_q, flush_q, bubble_q;
  logic [31:0] hold_d, flush_d, bubble_d;
  logic        ev_hold, ev_flush, ev_bub;

  assign ev_hold  = hold;
  assign ev_flush = !hold && flush;
  assign ev_bub   = !hold && !flush && hazard;

  // Saturating increments: stop at all-ones.
  always_comb begin
    hold_d   = hold_q;
    flush_d  = flush_q;
    bubble_d = bubble_q;
    if (ev_hold && !(&hold_q))
      hold_d = hold_q + 32'd1;
    if (ev_flush && !(&flush_q))
      flush_d = flush_q + 32'd1;
    if (ev_bub && !(&bubble_q))
      bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q   <= '0;
      flush_q  <= '0;
      bubble_q <= '0;
    end else begin
      hold_q   <= hold_d;
      flush_q  <= flush_d;
      bubble_q <= bubble_d;
    end
  end

  assign hold_cnt   = hold_q;
  assign flush_cnt  = flush_q;
  assign bubble_cnt = bubble_q;
`else
  assign hold_cnt   = '0;
  assign flush_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: directed plan plus random traffic.
// Counter checks are exercised when ID_EXE_PERF_CNT_EN is defined.
module tb_id_exe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [11:0] sh;
    logic        imm;
    logic [23:0] si24;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        b;
    logic        s;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        c;
  } in_t;

  typedef struct packed {
    in_t  d;
    logic mem;
    logic v;
  } out_t;

  typedef struct {
    out_t        o;
    logic [31:0] h;
    logic [31:0] f;
    logic [31:0] b;
  } exp_t;

`ifdef ID_EXE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, hold, flush, hazard;
  in_t  din;
  out_t dout;
  logic [31:0] bubble_cnt, flush_cnt, hold_cnt;

  always #5 clk = ~clk;

  id_exe_reg dut (
    .clk                 (clk),
    .rst                 (rst),
    .hold                (hold),
    .flush               (flush),
    .hazard              (hazard),
    .pc_in               (din.pc),
    .val_Rn_in           (din.rn),
    .val_Rm_in           (din.rm),
    .shifter_operand_in  (din.sh),
    .imm_in              (din.imm),
    .signed_imm_24_in    (din.si24),
    .exe_cmd_in          (din.cmd),
    .mem_r_en_in         (din.mr),
    .mem_w_en_in         (din.mw),
    .wb_en_in            (din.wb),
    .b_in                (din.b),
    .s_in                (din.s),
    .dest_in             (din.dest),
    .src1_in             (din.src1),
    .src2_in             (din.src2),
    .sr_c_in             (din.c),
    .pc_out              (dout.d.pc),
    .val_Rn_out          (dout.d.rn),
    .val_Rm_out          (dout.d.rm),
    .shifter_operand_out (dout.d.sh),
    .imm_out             (dout.d.imm),
    .signed_imm_24_out   (dout.d.si24),
    .exe_cmd_out         (dout.d.cmd),
    .mem_r_en_out        (dout.d.mr),
    .mem_w_en_out        (dout.d.mw),
    .wb_en_out           (dout.d.wb),
    .b_out               (dout.d.b),
    .s_out               (dout.d.s),
    .is_for_memory_out   (dout.mem),
    .dest_out            (dout.d.dest),
    .src1_out            (dout.d.src1),
    .src2_out            (dout.d.src2),
    .sr_c_out            (dout.d.c),
    .valid_out           (dout.v),
    .bubble_cnt          (bubble_cnt),
    .flush_cnt           (flush_cnt),
    .hold_cnt            (hold_cnt)
  );

  exp_t        sb[$];
  out_t        m_o;
  logic [31:0] m_h, m_f, m_b;
  int          n_chk = 0;
  int          n_err = 0;

  function automatic logic [31:0] sat(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  // Reference: one action per edge, rst > hold > flush > hazard > load.
  task automatic cyc(input logic r, input logic h,
                     input logic f, input logic z);
    exp_t e;
    rst = r; hold = h; flush = f; hazard = z;
    @(posedge clk);
    if (r) begin
      m_o = '0; m_h = 0; m_f = 0; m_b = 0;
    end else if (h) begin
      m_h = sat(m_h);
    end else if (f) begin
      m_o = '0; m_f = sat(m_f);
    end else if (z) begin
      m_o = '0; m_b = sat(m_b);
    end else begin
      m_o.d = din;
      m_o.mem = din.mr | din.mw;
      m_o.v = 1'b1;
    end
    e.o = m_o;
    e.h = PERF ? m_h : 32'd0;
    e.f = PERF ? m_f : 32'd0;
    e.b = PERF ? m_b : 32'd0;
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (dout !== e.o) begin
        n_err++;
        $display("FAIL outputs got=%h exp=%h", dout, e.o);
      end
      n_chk++;
      if (dout.v === 1'b0 && (dout.d.wb | dout.d.mr | dout.d.mw |
          dout.d.b | dout.d.s) !== 1'b0) begin
        n_err++;
        $display("FAIL killed_side_effects got=%b%b%b%b%b exp=00000",
                 dout.d.wb, dout.d.mr, dout.d.mw, dout.d.b, dout.d.s);
      end
      n_chk++;
      if ({hold_cnt, flush_cnt, bubble_cnt} !== {e.h, e.f, e.b}) begin
        n_err++;
        $display("FAIL counters got h=%h f=%h b=%h exp h=%h f=%h b=%h",
                 hold_cnt, flush_cnt, bubble_cnt, e.h, e.f, e.b);
      end
    end
  end

  initial begin
    m_o = '0; m_h = 0; m_f = 0; m_b = 0;
    rst = 1; hold = 1; flush = 1; hazard = 1;
    din = '1;
    cyc(1, 1, 1, 1);
    cyc(1, 1, 1, 1);

    din = '0;
    din.pc = 32'h10; din.rm = 32'h8000_0001; din.sh = 12'h0E3;
    din.imm = 1; din.cmd = 4'b0001; din.wb = 1; din.dest = 4'd3;
    cyc(0, 0, 0, 0);
    din.mw = 1;
    cyc(0, 0, 0, 0);
    din.mw = 0; din.mr = 1;
    cyc(0, 0, 0, 0);
    din.mr = 0;

    din.pc = 32'h20;
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      din.pc = 32'h100 + i; din.rn = $urandom;
      cyc(0, 1, 1, 0);
    end
    cyc(0, 0, 1, 0);

    din.wb = 1;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 1);
    cyc(0, 0, 0, 0);

`ifdef ID_EXE_PERF_CNT_EN
    @(negedge clk); #1;
    force dut.bubble_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_q;
    m_b = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
`endif

    for (int i = 0; i < 400; i++) begin
      din = in_t'({$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom});
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_chk++; n_err++;
      $display("FAIL drain got=%0d pending exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
